par2ser: RTL

PAR2SER -- requirements
Module: par2ser

---
 rtl/par2ser.sv | 70 +++++++
 1 files changed

// File: rtl/par2ser.sv
// par2ser: serializes parallel words into a valid-qualified bit stream and counts completed words
module par2ser #(
    parameter int       WIDTH     = 8,
    parameter bit       LSB_FIRST = 1'b1,
    parameter int       CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_rdy,
    output logic             din_vld,
    output logic             din,
    output logic             last,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             at_last, accept;

    // state registers; reset discards any partial word and its count immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shreg_q    <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // next state and outputs; the last-bit cycle doubles as a reload slot for gapless back-to-back words
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        word_cnt_d = word_cnt_q;
        at_last    = (state_q == SHIFT) && (idx_q == IDX_LAST);
        in_rdy     = (state_q == IDLE) || at_last;
        accept     = in_vld && in_rdy;
        din_vld    = (state_q == SHIFT);
        last       = at_last;
        din        = (state_q == SHIFT) && (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);
        word_cnt   = word_cnt_q;
        if (at_last)
            word_cnt_d = word_cnt_q + CNT_W'(1);
        if (accept) begin
            state_d = SHIFT;
            idx_d   = '0;
            shreg_d = in_data;
        end else if (at_last) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (state_q == SHIFT) begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        end
    end
endmodule
